alu_op_queue: RTL and testbench
===============================

# alu_op_queue

Operand/command queue that sits directly upstream of the 32-bit ALU in the Lab3 datapath. It buffers up to DEPTH operations (operandA, operandB, 3-bit command) behind a valid/ready handshake. It presents the head entry to the combinational ALU, then captures the ALU's result and zero flag into a registered output stage with its own valid/ready handshake. It decouples the operand producer from the result consumer and gives the ALU a full cycle of stable inputs.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  producer offers an operation
- in_ready  out  1  queue accepts; equals (count != DEPTH)
- in_a  in  WIDTH  operandA
- in_b  in  WIDTH  operandB
- in_cmd  in  3  ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7
- alu_a  out  WIDTH  head operandA to ALU; 0 when empty
- alu_b  out  WIDTH  head operandB to ALU; 0 when empty
- alu_cmd  out  3  head command to ALU; 0 when empty
- alu_result  in  WIDTH  ALU result for alu_a/alu_b/alu_cmd
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  out_result/out_zero/out_cmd hold a completed op
- out_ready  in  1  consumer accepts output
- out_result  out  WIDTH  registered ALU result
- out_zero  out  1  registered zero flag
- out_cmd  out  3  command that produced out_result
- count  out  $clog2(DEPTH)+1  entries in queue (excludes output register)
- flush  in  1  present only with ALU_OP_QUEUE_FLUSH_EN

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping DEPTH-1→0, plus a count register.
- Push: at a clock edge where in_valid && in_ready, write {in_a,in_b,in_cmd} at wr_ptr and advance wr_ptr.
- Head drive: alu_a/alu_b/alu_cmd come combinationally from the entry at rd_ptr; all are zero when count==0.
- Output register is "free" when !out_valid || out_ready.
- Pop: at an edge where count!=0 and the output register is free:
  - load out_result←alu_result, out_zero←alu_zero, out_cmd←alu_cmd;
  - set out_valid=1 and advance rd_ptr.
- If count==0 and out_valid && out_ready, clear out_valid to 0. The output data fields keep their last values.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full (count==DEPTH): in_ready=0 and in_valid is ignored. There is no same-cycle push on full, even if a pop occurs that edge.
- Empty (count==0): no pop. The bypass path from in_* straight to the ALU does not exist.
- Output backpressure: with out_valid=1 and out_ready=0, out_* hold steady, no pop occurs, and the queue fills.
- Results leave the block in strict push order.
- No arithmetic is done here. Widths pass through unchanged, and the ALU's SLT is unsigned.

## Timing
- Reset (async assert): count=0, pointers=0, in_ready=1, out_valid=0, out_result=0, out_zero=0, out_cmd=0, alu_*=0. Release is synchronous to clk; the first push is allowed at the first edge after deassertion.
- Reset asserted mid-operation discards all queued entries and the output register contents.
- Latency: an op accepted at edge N, with an empty queue and a free output, appears with out_valid=1 after edge N+1.
- Throughput: with out_ready held at 1, one result per cycle.
- in_ready and count are functions of registered state only. There is no combinational path from out_ready to in_ready.

## Configuration
- ALU_OP_QUEUE_FLUSH_EN defined: adds the flush input.
  - flush=1 at an edge sets count=0, both pointers=0 and out_valid=0.
  - A push or pop offered in the same cycle is dropped.
  - flush has priority below reset and above all other activity.
- Not defined: no flush port; the queue is cleared only by reset.

## Test plan
- Reset then single op: push a=5, b=3, cmd=SUB with out_ready=1 → out_valid=1 one cycle later, out_result=2, out_zero=0, out_cmd=1.
- Zero flag: push a=0x0000FFFF, b=0x0000FFFF, cmd=XOR → out_result=0, out_zero=1.
- Fill/backpressure (DEPTH=4): out_ready=0, push 6 ops ADD a=i, b=1 for i=0..5:
  - first op moves to output, next 4 queue; count=4, in_ready=0, 6th op is stalled;
  - raise out_ready → results 1,2,3,4,5,6 in order, one per cycle.
- Wrap-around: stream 10 ops OR a=i, b=0x100 with in_valid and out_ready held at 1 → outputs 0x100..0x109 in order; count never exceeds 1.
- Async reset mid-stream with 3 ops queued → out_valid=0, count=0 and in_ready=1 immediately, with no clock edge needed; the next op (AND 0xF0,0x3C) yields 0x30.
- With ALU_OP_QUEUE_FLUSH_EN: queue 3 ops, pulse flush one cycle together with in_valid → count=0, out_valid=0, and the concurrent push is discarded.

Source files
------------

// File: rtl/alu_op_queue.sv
// -----------------------------------------------------------------------------
// alu_op_queue
//
// Operand/command queue placed directly upstream of a combinational 32-bit ALU.
// Up to DEPTH operations {a, b, cmd} are buffered behind a valid/ready
// handshake. The head entry drives the ALU. The ALU's result and zero flag are
// captured into a registered output stage, which has its own valid/ready
// handshake. Results leave in strict push order.
//
// Optional feature macro: ALU_OP_QUEUE_FLUSH_EN (adds the flush input).
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   flush                   (ALU_OP_QUEUE_FLUSH_EN only) synchronous clear
//   in_valid/in_ready       producer handshake; in_ready = (count != DEPTH)
//   in_a, in_b, in_cmd      operation offered by the producer
//   alu_a, alu_b, alu_cmd   head entry presented to the ALU (zero when empty)
//   alu_result, alu_zero    ALU response for the head entry
//   out_valid/out_ready     consumer handshake
//   out_result, out_zero    registered ALU outputs
//   out_cmd                 command that produced out_result
//   count                   entries held in the queue (not the output stage)
// -----------------------------------------------------------------------------
module alu_op_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef ALU_OP_QUEUE_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2:0]               in_cmd,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_cmd,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_zero,
    output logic [2:0]               out_cmd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem_a   [DEPTH];
    logic [WIDTH-1:0] r_mem_b   [DEPTH];
    logic [2:0]       r_mem_cmd [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_zero;
    logic [2:0]       r_out_cmd;

    logic w_flush;
    logic w_full;
    logic w_empty;
    logic w_out_free;
    logic w_push;
    logic w_pop;

`ifdef ALU_OP_QUEUE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // in_ready depends only on the registered count, never on out_ready.
    assign w_full     = (r_count == FULL_C);
    assign w_empty    = (r_count == {CW{1'b0}});
    assign w_out_free = !r_out_valid || out_ready;
    assign w_push     = in_valid && !w_full;
    assign w_pop      = !w_empty && w_out_free;

    assign in_ready   = !w_full;
    assign count      = r_count;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_cmd    = r_out_cmd;

    // Head entry to the ALU; forced to zero while the queue is empty.
    always_comb begin
        alu_a   = {WIDTH{1'b0}};
        alu_b   = {WIDTH{1'b0}};
        alu_cmd = 3'd0;
        if (!w_empty) begin
            alu_a   = r_mem_a[r_rd_ptr];
            alu_b   = r_mem_b[r_rd_ptr];
            alu_cmd = r_mem_cmd[r_rd_ptr];
        end else begin
            alu_a   = {WIDTH{1'b0}};
            alu_b   = {WIDTH{1'b0}};
            alu_cmd = 3'd0;
        end
    end

    // Entry storage: written at wr_ptr on an accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i]   <= {WIDTH{1'b0}};
                r_mem_b[i]   <= {WIDTH{1'b0}};
                r_mem_cmd[i] <= 3'd0;
            end
        end else if (!w_flush && w_push) begin
            r_mem_a[r_wr_ptr]   <= in_a;
            r_mem_b[r_wr_ptr]   <= in_b;
            r_mem_cmd[r_wr_ptr] <= in_cmd;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (w_flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: capture the ALU response on a pop, drop valid once consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_result <= {WIDTH{1'b0}};
            r_out_zero   <= 1'b0;
            r_out_cmd    <= 3'd0;
        end else if (w_flush) begin
            r_out_valid  <= 1'b0;
        end else if (w_pop) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_zero   <= alu_zero;
            r_out_cmd    <= alu_cmd;
        end else if (r_out_valid && out_ready) begin
            // Data fields deliberately keep their last values.
            r_out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_op_queue
//
// Self-checking bench for alu_op_queue (DEPTH=4, WIDTH=32). A behavioural ALU
// closes the loop from alu_a/alu_b/alu_cmd to alu_result/alu_zero. Single-op
// vectors come from a table; fill/backpressure, wrap-around, async reset and
// (with ALU_OP_QUEUE_FLUSH_EN) flush are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_alu_op_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_cmd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_cmd;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [2:0]  out_cmd;
    logic [2:0]  count;
`ifdef ALU_OP_QUEUE_FLUSH_EN
    logic        flush;
`endif

    int checks;
    int failures;

    alu_op_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ALU_OP_QUEUE_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cmd     (in_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cmd    (alu_cmd),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_cmd    (out_cmd),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Lab3 ALU (SLT is unsigned).
    always_comb begin
        case (alu_cmd)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a ^ alu_b;
            3'd3:    alu_result = {31'd0, (alu_a < alu_b)};
            3'd4:    alu_result = alu_a & alu_b;
            3'd5:    alu_result = ~(alu_a & alu_b);
            3'd6:    alu_result = ~(alu_a | alu_b);
            3'd7:    alu_result = alu_a | alu_b;
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cmd;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cmd   = cmd;
    endtask

    initial begin
        int got;
        int gaps;
        int sent;
        int maxc;
        bit op5_pending;

        checks   = 0;
        failures = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_cmd    = 3'd0;
        out_ready = 1'b0;
`ifdef ALU_OP_QUEUE_FLUSH_EN
        flush     = 1'b0;
`endif

        vecs[0] = '{32'd5,        32'd3,        3'd1, 32'd2,        1'b0};
        vecs[1] = '{32'h0000FFFF, 32'h0000FFFF, 3'd2, 32'd0,        1'b1};
        vecs[2] = '{32'hFFFFFFFF, 32'd1,        3'd0, 32'd0,        1'b1};
        vecs[3] = '{32'd1,        32'hFFFFFFFF, 3'd3, 32'd1,        1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'd1,        3'd3, 32'd0,        1'b1};
        vecs[5] = '{32'h000000F0, 32'h0000003C, 3'd4, 32'h00000030, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'd0,        1'b1};
        vecs[7] = '{32'd0,        32'd0,        3'd6, 32'hFFFFFFFF, 1'b0};
        vecs[8] = '{32'h00000100, 32'd5,        3'd7, 32'h00000105, 1'b0};
        vecs[9] = '{32'd7,        32'd8,        3'd0, 32'd15,       1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_count",      32'(count),      32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_result", out_result,      32'd0);
        chk("rst_out_zero",   32'(out_zero),   32'd0);
        chk("rst_out_cmd",    32'(out_cmd),    32'd0);
        chk("rst_alu_a",      alu_a,           32'd0);
        chk("rst_alu_cmd",    32'(alu_cmd),    32'd0);
        reset = 1'b0;

        // Table-driven single operations
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].cmd);
            @(negedge clk);
            in_valid = 1'b0;
            chk("vec_count_after_push", 32'(count),     32'd1);
            chk("vec_out_valid_early",  32'(out_valid), 32'd0);
            chk("vec_head_alu_a",       alu_a,          vecs[i].a);
            @(negedge clk);
            chk("vec_out_valid",  32'(out_valid), 32'd1);
            chk("vec_out_result", out_result,     vecs[i].exp_res);
            chk("vec_out_zero",   32'(out_zero),  32'(vecs[i].exp_zero));
            chk("vec_out_cmd",    32'(out_cmd),   32'(vecs[i].cmd));
            chk("vec_count_done", 32'(count),     32'd0);
        end
        @(negedge clk);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_keeps_data", out_result, 32'd15);

        // Fill with output backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_op(32'(i), 32'd1, 3'd0);
            @(negedge clk);
        end
        chk("fill_count",     32'(count),     32'd4);
        chk("fill_in_ready",  32'(in_ready),  32'd0);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        chk("fill_out_hold",  out_result,     32'd1);
        @(negedge clk);
        chk("fill_stall_count", 32'(count), 32'd4);
        chk("fill_stall_out",   out_result, 32'd1);

        out_ready   = 1'b1;
        op5_pending = 1'b1;
        got  = 0;
        gaps = 0;
        for (int c = 0; c < 12 && got < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid) begin
                chk("drain_order", out_result, 32'(got + 1));
                got++;
            end else begin
                gaps++;
            end
            if (in_valid && !op5_pending) in_valid = 1'b0;
            if (op5_pending && in_ready) op5_pending = 1'b0;
        end
        chk("drain_total", 32'(got),  32'd6);
        chk("drain_gaps",  32'(gaps), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_end_valid", 32'(out_valid), 32'd0);
        chk("drain_end_count", 32'(count),     32'd0);

        // Wrap-around streaming
        got  = 0;
        sent = 0;
        maxc = 0;
        for (int c = 0; c < 16; c++) begin
            if (out_valid) begin
                chk("wrap_order", out_result, 32'h100 + 32'(got));
                got++;
            end
            if (int'(count) > maxc) maxc = int'(count);
            if (sent < 10) begin
                drive_op(32'(sent), 32'h100, 3'd7);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("wrap_total", 32'(got),  32'd10);
        chk("wrap_maxc",  32'(maxc), 32'd1);

        // Async reset with 3 ops queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(32'(i + 20), 32'd1, 3'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count),     32'd3);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count",     32'(count),     32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_result", out_result,    32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        drive_op(32'h000000F0, 32'h0000003C, 3'd4);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid",  32'(out_valid), 32'd1);
        chk("post_rst_result", out_result,     32'h00000030);
        @(negedge clk);

`ifdef ALU_OP_QUEUE_FLUSH_EN
        // Flush with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(32'(i), 32'd2, 3'd0);
            @(negedge clk);
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1;
        drive_op(32'd99, 32'd1, 3'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count",     32'(count),     32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("flush_push_dropped", 32'(count), 32'd0);
        chk("flush_alu_a",        alu_a,      32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
